// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables plus the ALU operation code for the shared Alu.
module multicycle_ctrl #(
   parameter logic [3:0] RESET_STATE  = 4'd0,
   parameter bit         TRAP_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCEn,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       RegWrite,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic       ExtOp,
   output logic [4:0] AluCtrl,
   output logic       IllegalInstr,
   output logic [3:0] State
);

   // Shared ALU operation encoding
   localparam logic [4:0] ALUOp_NOP  = 5'd0;
   localparam logic [4:0] ALUOp_ADD  = 5'd1;
   localparam logic [4:0] ALUOp_ADDU = 5'd2;
   localparam logic [4:0] ALUOp_SUB  = 5'd3;
   localparam logic [4:0] ALUOp_SUBU = 5'd4;
   localparam logic [4:0] ALUOp_AND  = 5'd5;
   localparam logic [4:0] ALUOp_OR   = 5'd6;
   localparam logic [4:0] ALUOp_XOR  = 5'd7;
   localparam logic [4:0] ALUOp_NOR  = 5'd8;
   localparam logic [4:0] ALUOp_SLT  = 5'd9;
   localparam logic [4:0] ALUOp_SLTU = 5'd10;
   localparam logic [4:0] ALUOp_LUI  = 5'd11;

   typedef enum logic [3:0] {
      Fetch   = 4'd0,  Decode = 4'd1,  MemAddr = 4'd2,  MemRd = 4'd3,
      MemWb   = 4'd4,  MemWr  = 4'd5,  RExec   = 4'd6,  RWb   = 4'd7,
      Branch  = 4'd8,  Jump   = 4'd9,  IExec   = 4'd10, IWb   = 4'd11,
      Jal     = 4'd12
   } stateT;

   stateT state, nextState;

   logic       opRType, opLw, opSw, opBeq, opBne, opJ, opJal, opIAlu;
   logic [4:0] functAlu, immAlu;
   logic       functValid, immSext, branchTaken;

   // Opcode class decode from the live instruction register fields
   always_comb begin
      opRType = (OpCode == 6'h00);
      opLw    = (OpCode == 6'h23);
      opSw    = (OpCode == 6'h2B);
      opBeq   = (OpCode == 6'h04);
      opBne   = (OpCode == 6'h05);
      opJ     = (OpCode == 6'h02);
      opJal   = (OpCode == 6'h03);
      opIAlu  = (OpCode[5:3] == 3'b001);
      branchTaken = (opBeq & Zero) | (opBne & ~Zero);
   end

   // R-type funct to ALU operation; unknown funct flagged invalid
   always_comb begin
      functAlu   = ALUOp_NOP;
      functValid = 1'b1;
      case (Funct)
         6'h20:   functAlu = ALUOp_ADD;
         6'h21:   functAlu = ALUOp_ADDU;
         6'h22:   functAlu = ALUOp_SUB;
         6'h23:   functAlu = ALUOp_SUBU;
         6'h24:   functAlu = ALUOp_AND;
         6'h25:   functAlu = ALUOp_OR;
         6'h26:   functAlu = ALUOp_XOR;
         6'h27:   functAlu = ALUOp_NOR;
         6'h2A:   functAlu = ALUOp_SLT;
         6'h2B:   functAlu = ALUOp_SLTU;
         default: functValid = 1'b0;
      endcase
   end

   // I-type ALU operation and immediate extension; logical ops zero-extend
   always_comb begin
      immAlu  = ALUOp_NOP;
      immSext = 1'b0;
      case (OpCode)
         6'h08:   begin immAlu = ALUOp_ADD;  immSext = 1'b1; end
         6'h09:   begin immAlu = ALUOp_ADDU; immSext = 1'b1; end
         6'h0A:   begin immAlu = ALUOp_SLT;  immSext = 1'b1; end
         6'h0B:   begin immAlu = ALUOp_SLTU; immSext = 1'b1; end
         6'h0C:   immAlu = ALUOp_AND;
         6'h0D:   immAlu = ALUOp_OR;
         6'h0E:   immAlu = ALUOp_XOR;
         6'h0F:   immAlu = ALUOp_LUI;
         default: immAlu = ALUOp_NOP;
      endcase
   end

   // State register; reset lands in Fetch
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= stateT'(RESET_STATE);
      else       state <= nextState;
   end

   // Next-state and Moore control outputs; PCEn is the only Zero-dependent output
   always_comb begin
      nextState    = Fetch;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      PCSource     = 2'd0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 2'd0;
      MemToReg     = 2'd0;
      RegWrite     = 1'b0;
      AluSrcA      = 1'b0;
      AluSrcB      = 2'd0;
      ExtOp        = 1'b0;
      AluCtrl      = ALUOp_NOP;
      IllegalInstr = 1'b0;
      case (state)
         Fetch: begin
            MemRead = 1'b1; IRWrite = 1'b1; AluSrcB = 2'd1;
            AluCtrl = ALUOp_ADDU; PCWrite = 1'b1;
            nextState = Decode;
         end
         Decode: begin
            AluSrcB = 2'd3; ExtOp = 1'b1; AluCtrl = ALUOp_ADDU;
            if (opLw | opSw)         nextState = MemAddr;
            else if (opRType)        nextState = RExec;
            else if (opBeq | opBne)  nextState = Branch;
            else if (opJ)            nextState = Jump;
            else if (opJal)          nextState = Jal;
            else if (opIAlu)         nextState = IExec;
            else                     IllegalInstr = TRAP_ILLEGAL;
         end
         MemAddr: begin
            AluSrcA = 1'b1; AluSrcB = 2'd2; ExtOp = 1'b1; AluCtrl = ALUOp_ADD;
            if (opLw)      nextState = MemRd;
            else if (opSw) nextState = MemWr;
         end
         MemRd: begin
            IorD = 1'b1; MemRead = 1'b1;
            nextState = MemWb;
         end
         MemWb: begin
            MemToReg = 2'd1; RegWrite = 1'b1;
         end
         MemWr: begin
            IorD = 1'b1; MemWrite = 1'b1;
         end
         RExec: begin
            AluSrcA = 1'b1;
            if (functValid) begin
               AluCtrl   = functAlu;
               nextState = RWb;
            end else begin
               IllegalInstr = TRAP_ILLEGAL;
            end
         end
         RWb: begin
            RegDst = 2'd1; RegWrite = 1'b1;
         end
         Branch: begin
            AluSrcA = 1'b1; AluCtrl = ALUOp_SUB; PCSource = 2'd1; PCWriteCond = 1'b1;
         end
         Jump: begin
            PCSource = 2'd2; PCWrite = 1'b1;
         end
         Jal: begin
            PCSource = 2'd2; PCWrite = 1'b1; RegDst = 2'd2; MemToReg = 2'd2; RegWrite = 1'b1;
         end
         IExec: begin
            AluSrcA = 1'b1; AluSrcB = 2'd2; AluCtrl = immAlu; ExtOp = immSext;
            nextState = IWb;
         end
         IWb: begin
            RegWrite = 1'b1;
         end
         default: nextState = Fetch;
      endcase
      PCEn = PCWrite | (PCWriteCond & branchTaken);
      // Reset suppresses every enable, independent of the state register
      if (!rstn) begin
         PCWrite = 1'b0; PCWriteCond = 1'b0; PCEn = 1'b0; PCSource = 2'd0;
         IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
         RegDst = 2'd0; MemToReg = 2'd0; RegWrite = 1'b0; AluSrcA = 1'b0;
         AluSrcB = 2'd0; ExtOp = 1'b0; AluCtrl = ALUOp_NOP; IllegalInstr = 1'b0;
      end
   end

   assign State = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, reset corner cases,
// and random instruction streams against an instruction-level reference model.
module tb_multicycle_ctrl;

   localparam logic [4:0] A_NOP = 5'd0,  A_ADD = 5'd1,  A_ADDU = 5'd2, A_SUB  = 5'd3;
   localparam logic [4:0] A_SUBU = 5'd4, A_AND = 5'd5,  A_OR   = 5'd6, A_XOR  = 5'd7;
   localparam logic [4:0] A_NOR = 5'd8,  A_SLT = 5'd9,  A_SLTU = 5'd10, A_LUI = 5'd11;

   typedef struct packed {
      logic [3:0] state;
      logic       pcWrite, pcWriteCond, pcEn;
      logic [1:0] pcSource;
      logic       iorD, memRead, memWrite, irWrite;
      logic [1:0] regDst, memToReg;
      logic       regWrite, aluSrcA;
      logic [1:0] aluSrcB;
      logic       extOp;
      logic [4:0] aluCtrl;
      logic       illegal;
   } ctrlT;

   typedef struct {
      logic [5:0] op, funct;
      logic       zero;
      int         probe;
      logic [4:0] aluCtrl;
      logic       extOp, pcEn, illegal, regWrite;
      int         lat;
   } vecT;

   typedef int intQ[$];

   logic clk = 1'b0, rstn = 1'b0;
   logic [5:0] OpCode = 6'h00, Funct = 6'h00;
   logic Zero = 1'b0;
   logic PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, AluSrcA;
   logic ExtOp, IllegalInstr;
   logic [1:0] PCSource, RegDst, MemToReg, AluSrcB;
   logic [4:0] AluCtrl;
   logic [3:0] State;

   int nVec = 0, nErr = 0;
   ctrlT baseTbl [13];
   logic [4:0] aluOfFunct [64];
   logic       functOk    [64];
   logic [4:0] aluOfOp    [64];
   logic       sextOfOp   [64];

   multicycle_ctrl dut (
      .clk(clk), .rstn(rstn), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .PCSource(PCSource),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
      .AluSrcB(AluSrcB), .ExtOp(ExtOp), .AluCtrl(AluCtrl), .IllegalInstr(IllegalInstr),
      .State(State)
   );

   always #5 clk = ~clk;

   function automatic ctrlT sample();
      ctrlT s;
      s = '{State, PCWrite, PCWriteCond, PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite,
            RegDst, MemToReg, RegWrite, AluSrcA, AluSrcB, ExtOp, AluCtrl, IllegalInstr};
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-state control words and the opcode/funct lookup tables of the ISA subset
   task automatic initTables();
      for (int i = 0; i < 13; i++) begin
         baseTbl[i] = '0;
         baseTbl[i].state = 4'(i);
      end
      baseTbl[0].pcWrite = 1; baseTbl[0].memRead = 1; baseTbl[0].irWrite = 1;
      baseTbl[0].aluSrcB = 2'd1; baseTbl[0].aluCtrl = A_ADDU;
      baseTbl[1].aluSrcB = 2'd3; baseTbl[1].extOp = 1; baseTbl[1].aluCtrl = A_ADDU;
      baseTbl[2].aluSrcA = 1; baseTbl[2].aluSrcB = 2'd2; baseTbl[2].extOp = 1; baseTbl[2].aluCtrl = A_ADD;
      baseTbl[3].iorD = 1; baseTbl[3].memRead = 1;
      baseTbl[4].memToReg = 2'd1; baseTbl[4].regWrite = 1;
      baseTbl[5].iorD = 1; baseTbl[5].memWrite = 1;
      baseTbl[6].aluSrcA = 1;
      baseTbl[7].regDst = 2'd1; baseTbl[7].regWrite = 1;
      baseTbl[8].aluSrcA = 1; baseTbl[8].aluCtrl = A_SUB; baseTbl[8].pcSource = 2'd1;
      baseTbl[8].pcWriteCond = 1;
      baseTbl[9].pcSource = 2'd2; baseTbl[9].pcWrite = 1;
      baseTbl[10].aluSrcA = 1; baseTbl[10].aluSrcB = 2'd2;
      baseTbl[11].regWrite = 1;
      baseTbl[12].pcSource = 2'd2; baseTbl[12].pcWrite = 1; baseTbl[12].regDst = 2'd2;
      baseTbl[12].memToReg = 2'd2; baseTbl[12].regWrite = 1;
      for (int i = 0; i < 64; i++) begin
         aluOfFunct[i] = A_NOP; functOk[i] = 0; aluOfOp[i] = A_NOP; sextOfOp[i] = 0;
      end
      aluOfFunct[6'h20] = A_ADD;  aluOfFunct[6'h21] = A_ADDU; aluOfFunct[6'h22] = A_SUB;
      aluOfFunct[6'h23] = A_SUBU; aluOfFunct[6'h24] = A_AND;  aluOfFunct[6'h25] = A_OR;
      aluOfFunct[6'h26] = A_XOR;  aluOfFunct[6'h27] = A_NOR;  aluOfFunct[6'h2A] = A_SLT;
      aluOfFunct[6'h2B] = A_SLTU;
      for (int i = 0; i < 64; i++) functOk[i] = (aluOfFunct[i] != A_NOP);
      aluOfOp[6'h08] = A_ADD; aluOfOp[6'h09] = A_ADDU; aluOfOp[6'h0A] = A_SLT; aluOfOp[6'h0B] = A_SLTU;
      aluOfOp[6'h0C] = A_AND; aluOfOp[6'h0D] = A_OR;   aluOfOp[6'h0E] = A_XOR; aluOfOp[6'h0F] = A_LUI;
      for (int i = 8; i < 12; i++) sextOfOp[i] = 1;
   endtask

   function automatic bit isIAlu(input logic [5:0] op);
      return (op >= 6'h08) && (op <= 6'h0F);
   endfunction

   function automatic bit knownOp(input logic [5:0] op);
      return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05 ||
             op == 6'h02 || op == 6'h03 || isIAlu(op);
   endfunction

   // States visited by one instruction, first Fetch up to the return to Fetch
   function automatic intQ pathOf(input logic [5:0] op, input logic [5:0] funct);
      intQ q;
      case (op)
         6'h23:        q = '{0, 1, 2, 3, 4};
         6'h2B:        q = '{0, 1, 2, 5};
         6'h00:        q = functOk[funct] ? '{0, 1, 6, 7} : '{0, 1, 6};
         6'h04, 6'h05: q = '{0, 1, 8};
         6'h02:        q = '{0, 1, 9};
         6'h03:        q = '{0, 1, 12};
         default:      q = isIAlu(op) ? '{0, 1, 10, 11} : '{0, 1};
      endcase
      return q;
   endfunction

   function automatic ctrlT expWord(input int st, input logic [5:0] op, input logic [5:0] funct,
                                    input logic zero);
      ctrlT w;
      bit taken;
      w = baseTbl[st];
      if (st == 1 && !knownOp(op)) w.illegal = 1;
      if (st == 6) begin
         w.aluCtrl = aluOfFunct[funct];
         w.illegal = !functOk[funct];
      end
      if (st == 10) begin
         w.aluCtrl = aluOfOp[op];
         w.extOp   = sextOfOp[op];
      end
      taken = (op == 6'h04 && zero) || (op == 6'h05 && !zero);
      w.pcEn = w.pcWrite | (w.pcWriteCond & taken);
      return w;
   endfunction

   // Run one instruction from Fetch; entered and left at posedge+1 with the DUT in Fetch
   task automatic runInstr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input int probe, output ctrlT probeObs, output int lat);
      intQ  path;
      ctrlT obs, exp;
      path = pathOf(op, funct);
      OpCode = op; Funct = funct; Zero = zero;
      probeObs = '1;
      lat = 0;
      do begin
         @(negedge clk);
         obs = sample();
         exp = expWord((lat < path.size()) ? path[lat] : 0, op, funct, zero);
         chk($sformatf("ctrl op=%h fn=%h cyc%0d", op, funct, lat), 64'(obs), 64'(exp));
         if (int'(obs.state) == probe) probeObs = obs;
         @(posedge clk); #1;
         lat++;
      end while (State != 4'd0 && lat < 12);
      if (lat >= 12) $display("FAIL timeout op=%h: no return to Fetch within 12 cycles", op);
      chk($sformatf("latency op=%h fn=%h", op, funct), 64'(lat), 64'(path.size()));
   endtask

   vecT  vecs[$];
   ctrlT pObs;
   int   lat;
   logic [5:0] opList [15] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                               6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
   logic [5:0] fnList [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B};

   initial begin
      initTables();
      //         op     funct  z  probe alu     ext pcEn ill rw  lat
      vecs.push_back('{6'h23, 6'h00, 0, 3,  A_NOP,  0,  0,  0,  0,  5});
      vecs.push_back('{6'h23, 6'h00, 0, 4,  A_NOP,  0,  0,  0,  1,  5});
      vecs.push_back('{6'h2B, 6'h00, 0, 5,  A_NOP,  0,  0,  0,  0,  4});
      vecs.push_back('{6'h00, 6'h2B, 0, 6,  A_SLTU, 0,  0,  0,  0,  4});
      vecs.push_back('{6'h00, 6'h21, 0, 6,  A_ADDU, 0,  0,  0,  0,  4});
      vecs.push_back('{6'h00, 6'h3F, 0, 6,  A_NOP,  0,  0,  1,  0,  3});
      vecs.push_back('{6'h04, 6'h00, 1, 8,  A_SUB,  0,  1,  0,  0,  3});
      vecs.push_back('{6'h05, 6'h00, 1, 8,  A_SUB,  0,  0,  0,  0,  3});
      vecs.push_back('{6'h05, 6'h00, 0, 8,  A_SUB,  0,  1,  0,  0,  3});
      vecs.push_back('{6'h0D, 6'h00, 0, 10, A_OR,   0,  0,  0,  0,  4});
      vecs.push_back('{6'h08, 6'h00, 0, 10, A_ADD,  1,  0,  0,  0,  4});
      vecs.push_back('{6'h0F, 6'h00, 0, 10, A_LUI,  0,  0,  0,  0,  4});
      vecs.push_back('{6'h03, 6'h00, 0, 12, A_NOP,  0,  1,  0,  1,  3});
      vecs.push_back('{6'h02, 6'h00, 0, 9,  A_NOP,  0,  1,  0,  0,  3});
      vecs.push_back('{6'h3F, 6'h00, 0, 1,  A_ADDU, 1,  0,  1,  0,  2});

      // Reset held three cycles: everything off, State at Fetch
      repeat (3) @(posedge clk);
      #1;
      chk("in-reset outputs", 64'(sample()), 64'(ctrlT'('0)));
      rstn = 1'b1;
      #1;
      chk("first Fetch after reset", 64'(sample()), 64'(expWord(0, OpCode, Funct, Zero)));

      // Directed table
      foreach (vecs[i]) begin
         runInstr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].probe, pObs, lat);
         chk($sformatf("probe vec%0d", i),
             64'({pObs.state, pObs.aluCtrl, pObs.extOp, pObs.pcEn, pObs.illegal, pObs.regWrite}),
             64'({4'(vecs[i].probe), vecs[i].aluCtrl, vecs[i].extOp, vecs[i].pcEn,
                  vecs[i].illegal, vecs[i].regWrite}));
         chk($sformatf("latency vec%0d", i), 64'(lat), 64'(vecs[i].lat));
      end

      // jal interrupted by reset in its last state: outputs drop at once
      OpCode = 6'h03; Funct = 6'h00; Zero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("jal reaches state 12", 64'({State, RegWrite, RegDst, MemToReg}), 64'({4'd12, 1'b1, 2'd2, 2'd2}));
      #2 rstn = 1'b0;
      #1 chk("async reset mid-jal", 64'(sample()), 64'(ctrlT'('0)));
      @(posedge clk); #1;
      chk("reset held across edge", 64'(sample()), 64'(ctrlT'('0)));
      rstn = 1'b1;
      #1 chk("Fetch after mid-jal reset", 64'(sample()), 64'(expWord(0, OpCode, Funct, Zero)));

      // Random instruction stream against the model
      for (int n = 0; n < 300; n++) begin
         logic [5:0] op, fn;
         logic z;
         op = ($urandom_range(3) != 0) ? opList[$urandom_range(14)] : 6'($urandom);
         fn = ($urandom_range(1) != 0) ? fnList[$urandom_range(9)]  : 6'($urandom);
         z  = 1'($urandom);
         runInstr(op, fn, z, -1, pObs, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
